// File: rtl/regfile_arb.sv
// rtl/regfile_arb.sv - round-robin arbiter sharing one register-file port among rn requesters
// Writes to the status region (address MSB set) are blocked and reported with err_o.
module regfile_arb #(
  parameter int rn = 2,
  parameter int aw = 7,
  parameter int dw = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [rn-1:0] req_i,
  input  logic [rn-1:0] we_i,
  input  logic [aw-1:0] addr_i [rn],
  input  logic [dw-1:0] wdata_i [rn],
  output logic [rn-1:0] ack_o,
  output logic          err_o,
  output logic [dw-1:0] rdata_o,
  output logic          busy_o,
  output logic [aw-1:0] rf_addr_o,
  output logic [dw-1:0] rf_data_o,
  output logic          rf_wren_o,
  input  logic [dw-1:0] rf_data_i
);

  localparam int gw = (rn > 1) ? $clog2(rn) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [gw-1:0] last;
  logic [gw-1:0] pick;
  logic          pick_vld;
  logic          lat_we;
  logic          err_q;
  logic [gw:0]   cand;

  // Scan downward so the nearest set bit above last overwrites farther ones.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = rn; i >= 1; i--) begin
      cand = {1'b0, last} + (gw + 1)'(i);
      if (cand >= (gw + 1)'(rn)) cand = cand - (gw + 1)'(rn);
      if (req_i[cand[gw-1:0]]) begin
        pick     = cand[gw-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ack_o     = '0;
    err_o     = 1'b0;
    busy_o    = 1'b0;
    rf_wren_o = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) state_nx = ACCESS;
      end
      ACCESS: begin
        busy_o    = 1'b1;
        rf_wren_o = lat_we & ~rf_addr_o[aw-1];
        state_nx  = DONE;
      end
      DONE: begin
        busy_o      = 1'b1;
        ack_o[last] = 1'b1;
        err_o       = err_q;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // last doubles as the grant index of the transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last      <= gw'(rn - 1);
      rf_addr_o <= '0;
      rf_data_o <= '0;
      lat_we    <= 1'b0;
      err_q     <= 1'b0;
      rdata_o   <= '0;
    end else begin
      if (state == IDLE && pick_vld) begin
        last      <= pick;
        rf_addr_o <= addr_i[pick];
        rf_data_o <= wdata_i[pick];
        lat_we    <= we_i[pick];
      end
      if (state == ACCESS) begin
        err_q <= lat_we & rf_addr_o[aw-1];
        if (!lat_we) rdata_o <= rf_data_i;
      end
    end
  end

endmodule

// File: tb/tb_regfile_arb.sv
// tb/tb_regfile_arb.sv - scoreboard bench for regfile_arb with a round-robin reference model
// A rn=2 instance takes random traffic; a rn=4 instance checks pointer rotation.
module tb_regfile_arb;

  typedef struct {
    int         cyc;
    logic [3:0] ack;
    logic       err;
    logic       chk_rd;
    logic [7:0] rdata;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, we;
  logic [6:0] addr [2];
  logic [7:0] wdata [2];
  logic [1:0] ack;
  logic       err, busy, rf_wren;
  logic [7:0] rdata, rf_data, rf_rd;
  logic [6:0] rf_addr;

  logic [3:0] req4, we4;
  logic [6:0] addr4 [4];
  logic [7:0] wdata4 [4];
  logic [3:0] ack4;
  logic       err4, busy4, rf_wren4;
  logic [7:0] rdata4, rf_data4;
  logic [6:0] rf_addr4;
  logic [7:0] rf_rd4;

  logic [7:0] rf_mem [128];
  logic [7:0] ref_mem [128];
  logic       ld_en = 1'b0;
  logic [6:0] ld_a;
  logic [7:0] ld_d;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ref_last = 1;
  int   ref4 = 3;
  exp_t expq[$];
  exp_t exp4[$];
  wr_t  wq[$];
  exp_t me, me4;
  wr_t  mw;

  regfile_arb #(.rn(2), .aw(7), .dw(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack), .err_o(err), .rdata_o(rdata), .busy_o(busy), .rf_addr_o(rf_addr),
    .rf_data_o(rf_data), .rf_wren_o(rf_wren), .rf_data_i(rf_rd)
  );

  regfile_arb #(.rn(4), .aw(7), .dw(8)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .req_i(req4), .we_i(we4), .addr_i(addr4), .wdata_i(wdata4),
    .ack_o(ack4), .err_o(err4), .rdata_o(rdata4), .busy_o(busy4), .rf_addr_o(rf_addr4),
    .rf_data_o(rf_data4), .rf_wren_o(rf_wren4), .rf_data_i(rf_rd4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rf_rd  = rf_mem[rf_addr];
  assign rf_rd4 = 8'h5A;

  always @(posedge clk) begin
    if (ld_en)        rf_mem[ld_a] <= ld_d;
    else if (rf_wren) rf_mem[rf_addr] <= rf_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int n, input int lst, input int reqv);
    for (int k = 1; k <= n; k++) begin
      int c = (lst + k) % n;
      if (reqv[c]) return c;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (ack != 2'b00 || err) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL ack_unexpected: ack=%b err=%b with nothing outstanding", ack, err);
        end else begin
          me = expq.pop_front();
          check("ack_cycle", cyc, me.cyc);
          check("ack_vec", {30'd0, ack}, {28'd0, me.ack});
          check("err", {31'd0, err}, {31'd0, me.err});
          if (me.chk_rd) check("rdata", {24'd0, rdata}, {24'd0, me.rdata});
        end
      end
      if (rf_wren) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL wren_unexpected: addr=%h data=%h with no write outstanding", rf_addr, rf_data);
        end else begin
          mw = wq.pop_front();
          check("wren_cycle", cyc, mw.cyc);
          check("wren_addr", {25'd0, rf_addr}, {25'd0, mw.a});
          check("wren_data", {24'd0, rf_data}, {24'd0, mw.d});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (ack4 != 4'b0000 || err4)) begin
      if (exp4.size() == 0) begin
        checks++; errors++;
        $display("FAIL ack4_unexpected: ack=%b err=%b with nothing outstanding", ack4, err4);
      end else begin
        me4 = exp4.pop_front();
        check("ack4_cycle", cyc, me4.cyc);
        check("ack4_vec", {28'd0, ack4}, {28'd0, me4.ack});
        check("ack4_rdata", {24'd0, rdata4}, {24'd0, me4.rdata});
      end
    end
  end

  // Called at a negedge while the arbiter is idle; returns at the next idle negedge.
  task automatic issue(input logic [1:0] r, input logic [1:0] w, input logic [6:0] a0,
                       input logic [6:0] a1, input logic [7:0] d0, input logic [7:0] d1,
                       input bit drop);
    int         g;
    logic [6:0] ag;
    logic [7:0] dg;
    exp_t       e;
    req = r; we = w; addr[0] = a0; addr[1] = a1; wdata[0] = d0; wdata[1] = d1;
    if (r == 2'b00) begin
      @(posedge clk); @(negedge clk);
      check("busy_idle", {31'd0, busy}, 0);
    end else begin
      g = rr_pick(2, ref_last, int'(r));
      ref_last = g;
      ag = (g == 0) ? a0 : a1;
      dg = (g == 0) ? d0 : d1;
      e.cyc = cyc + 2;
      e.ack = 4'(1 << g);
      e.err = w[g] & ag[6];
      e.chk_rd = !w[g];
      e.rdata = ref_mem[ag];
      if (w[g] && !ag[6]) begin
        wq.push_back('{cyc: cyc + 1, a: ag, d: dg});
        ref_mem[ag] = dg;
      end
      expq.push_back(e);
      @(posedge clk); @(negedge clk);
      check("busy_access", {31'd0, busy}, 1);
      if (drop) req = 2'b00;
      @(posedge clk); @(negedge clk);
      check("busy_done", {31'd0, busy}, 1);
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    int base;
    exp_t e4;
    rst = 1'b1;
    req = '0; we = '0; addr = '{default: '0}; wdata = '{default: '0};
    req4 = '0; we4 = '0; addr4 = '{default: '0}; wdata4 = '{default: '0};
    for (int i = 0; i < 128; i++) begin
      ld_a = 7'(i);
      ld_d = (i == 'h45) ? 8'h3C : 8'($urandom);
      ref_mem[i] = ld_d;
      ld_en = 1'b1;
      @(negedge clk);
    end
    ld_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ack", {30'd0, ack}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_rdata", {24'd0, rdata}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_rf_addr", {25'd0, rf_addr}, 0);
    check("rst_rf_data", {24'd0, rf_data}, 0);
    check("rst_wren", {31'd0, rf_wren}, 0);
    @(negedge clk);

    issue(2'b01, 2'b01, 7'h05, 7'h00, 8'hA5, 8'h00, 1'b0);
    issue(2'b10, 2'b00, 7'h00, 7'h45, 8'h00, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) issue(2'b11, 2'b00, 7'h10, 7'h45, 8'h00, 8'h00, 1'b0);
    issue(2'b01, 2'b01, 7'h40, 7'h00, 8'h11, 8'h00, 1'b1);
    issue(2'b00, 2'b00, 7'h00, 7'h00, 8'h00, 8'h00, 1'b0);

    // Reset lands in ACCESS of a write to 0x02.
    req = 2'b01; we = 2'b01; addr[0] = 7'h02; wdata[0] = ~ref_mem[2];
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_wren", {31'd0, rf_wren}, 0);
    check("rst_mid_busy", {31'd0, busy}, 0);
    check("rst_mid_ack", {30'd0, ack}, 0);
    check("rst_mid_rf_data", {24'd0, rf_data}, 0);
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    ref_last = 1;
    @(negedge clk);
    check("rst_mid_mem", {24'd0, rf_mem[2]}, {24'd0, ref_mem[2]});
    issue(2'b11, 2'b00, 7'h02, 7'h03, 8'h00, 8'h00, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_last = 1;
    issue(2'b10, 2'b00, 7'h02, 7'h45, 8'h00, 8'h00, 1'b1);

    for (int t = 0; t < 200; t++)
      issue(2'($urandom_range(0, 3)), 2'($urandom), 7'($urandom), 7'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    issue(2'b00, 2'b00, 7'h00, 7'h00, 8'h00, 8'h00, 1'b0);

    // rn=4: park the pointer on 1, then hold requesters 1 and 3.
    req4 = 4'b0010;
    e4 = '{cyc: cyc + 2, ack: 4'b0010, err: 1'b0, chk_rd: 1'b1, rdata: 8'h5A};
    exp4.push_back(e4);
    ref4 = 1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    req4 = 4'b1010;
    base = cyc;
    for (int k = 0; k < 4; k++) begin
      ref4 = rr_pick(4, ref4, 'b1010);
      e4 = '{cyc: base + 3 * k + 2, ack: 4'(1 << ref4), err: 1'b0, chk_rd: 1'b1, rdata: 8'h5A};
      exp4.push_back(e4);
    end
    repeat (12) begin @(posedge clk); @(negedge clk); end
    req4 = 4'b0000;

    repeat (6) @(negedge clk);
    check("ack_left", expq.size(), 0);
    check("wren_left", wq.size(), 0);
    check("ack4_left", exp4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
